// File: rtl/despacho_ula.sv
`default_nettype none
// ============================================================================
// Module      : despacho_ula
// Description : Dispatch/writeback stage in front of the multi-cycle ALU.
//               8-entry register file, processar/concluido handshake.
// Revision    : 1.0
// ============================================================================
module despacho_ula #(
    parameter int WIDTH   = 16,
    parameter int NREG    = 8,
    parameter int TIMEOUT = 32,
    localparam int c_ADDR_W = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [3:0]          instr_op,
    input  logic [c_ADDR_W-1:0] instr_rd,
    input  logic [c_ADDR_W-1:0] instr_rs1,
    input  logic [c_ADDR_W-1:0] instr_rs2,
    input  logic                ld_en,
    input  logic [c_ADDR_W-1:0] ld_addr,
    input  logic [WIDTH-1:0]    ld_data,
    input  logic [c_ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]    rd_data,
    output logic [WIDTH-1:0]    alu_tp1,
    output logic [WIDTH-1:0]    alu_tp2,
    output logic [3:0]          alu_op,
    output logic                alu_processar,
    input  logic                alu_concluido,
    input  logic [WIDTH-1:0]    alu_data,
    output logic                wb_valid,
    output logic [c_ADDR_W-1:0] wb_rd,
    output logic [WIDTH-1:0]    wb_data,
    output logic                err_op,
    output logic                err_timeout
);
    localparam int c_CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LE      = 3'd1,
        S_EMITE   = 3'd2,
        S_ESCREVE = 3'd3,
        S_LIBERA  = 3'd4,
        S_ERRO    = 3'd5
    } state_t;

    state_t              r_state;
    logic [WIDTH-1:0]    r_regs [NREG];
    logic [3:0]          r_op;
    logic [c_ADDR_W-1:0] r_rd;
    logic [c_ADDR_W-1:0] r_rs1;
    logic [c_ADDR_W-1:0] r_rs2;
    logic [WIDTH-1:0]    r_tp1;
    logic [WIDTH-1:0]    r_tp2;
    logic [3:0]          r_alu_op;
    logic                r_processar;
    logic                r_wb_valid;
    logic [c_ADDR_W-1:0] r_wb_rd;
    logic [WIDTH-1:0]    r_wb_data;
    logic                r_err_op;
    logic                r_err_timeout;
    logic [c_CNT_W-1:0]  r_cnt;

    logic                w_illegal;
    logic                w_wb_write;

    assign w_illegal  = (instr_op > 4'd9);
    assign w_wb_write = (r_state == S_ESCREVE);

    assign instr_ready   = (r_state == S_IDLE);
    assign rd_data       = r_regs[rd_addr];
    assign alu_tp1       = r_tp1;
    assign alu_tp2       = r_tp2;
    assign alu_op        = r_alu_op;
    assign alu_processar = r_processar;
    assign wb_valid      = r_wb_valid;
    assign wb_rd         = r_wb_rd;
    assign wb_data       = r_wb_data;
    assign err_op        = r_err_op;
    assign err_timeout   = r_err_timeout;

    // Writeback has priority over the direct load port on the same address.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (w_wb_write && (r_wb_rd == c_ADDR_W'(i))) begin
                    r_regs[i] <= r_wb_data;
                end else if (ld_en && (ld_addr == c_ADDR_W'(i))) begin
                    r_regs[i] <= ld_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_op          <= '0;
            r_rd          <= '0;
            r_rs1         <= '0;
            r_rs2         <= '0;
            r_tp1         <= '0;
            r_tp2         <= '0;
            r_alu_op      <= '0;
            r_processar   <= 1'b0;
            r_wb_valid    <= 1'b0;
            r_wb_rd       <= '0;
            r_wb_data     <= '0;
            r_err_op      <= 1'b0;
            r_err_timeout <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_wb_valid <= 1'b0;
            r_err_op   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        if (w_illegal) begin
                            r_err_op <= 1'b1;
                        end else begin
                            r_op    <= instr_op;
                            r_rd    <= instr_rd;
                            r_rs1   <= instr_rs1;
                            r_rs2   <= instr_rs2;
                            r_state <= S_LE;
                        end
                    end
                end
                S_LE: begin
                    r_tp1       <= r_regs[r_rs1];
                    r_tp2       <= r_regs[r_rs2];
                    r_alu_op    <= r_op;
                    r_cnt       <= '0;
                    r_processar <= 1'b1;
                    r_state     <= S_EMITE;
                end
                S_EMITE: begin
                    // Completion takes precedence over a timeout in the same cycle.
                    if (alu_concluido) begin
                        r_wb_data   <= alu_data;
                        r_wb_rd     <= r_rd;
                        r_wb_valid  <= 1'b1;
                        r_processar <= 1'b0;
                        r_state     <= S_ESCREVE;
                    end else if (r_cnt == c_CNT_W'(TIMEOUT - 1)) begin
                        r_processar   <= 1'b0;
                        r_err_timeout <= 1'b1;
                        r_state       <= S_ERRO;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                S_ESCREVE: begin
                    r_state <= S_LIBERA;
                end
                S_LIBERA: begin
                    if (!alu_concluido) begin
                        r_state <= S_IDLE;
                    end
                end
                S_ERRO: begin
                    r_state <= S_ERRO;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_despacho_ula.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_despacho_ula
// Description : Directed self-checking bench for despacho_ula with ALU model.
// Revision    : 1.0
// ============================================================================
module tb_despacho_ula;
    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  instr_op;
    logic [2:0]  instr_rd, instr_rs1, instr_rs2;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic [2:0]  rd_addr;
    logic [15:0] rd_data;
    logic [15:0] alu_tp1, alu_tp2;
    logic [3:0]  alu_op;
    logic        alu_processar;
    logic        alu_concluido = 1'b0;
    logic [15:0] alu_data = 16'h0;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic        err_op, err_timeout;

    despacho_ula #(.WIDTH(16), .NREG(8), .TIMEOUT(32)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
        .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .alu_tp1(alu_tp1), .alu_tp2(alu_tp2), .alu_op(alu_op),
        .alu_processar(alu_processar), .alu_concluido(alu_concluido), .alu_data(alu_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .err_op(err_op), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a * b;
            4'd3: r = a & b;
            4'd4: r = a | b;
            4'd5: r = a ^ b;
            4'd6: r = a << b[3:0];
            4'd7: r = a >> b[3:0];
            4'd8: r = ~a;
            default: r = a;
        endcase
        return r;
    endfunction

    // ALU responder: answers after alu_lat cycles, releases alu_rel cycles after processar falls
    int alu_lat  = 3;
    int alu_rel  = 0;
    bit alu_dead = 1'b0;
    int alu_cnt  = 0;
    always @(posedge clk) begin
        if (reset) begin
            alu_concluido <= 1'b0;
            alu_cnt       <= 0;
        end else if (alu_processar && !alu_concluido) begin
            if (!alu_dead && alu_cnt >= alu_lat - 1) begin
                alu_concluido <= 1'b1;
                alu_data      <= alu_f(alu_op, alu_tp1, alu_tp2);
                alu_cnt       <= 0;
            end else begin
                alu_cnt <= alu_cnt + 1;
            end
        end else if (!alu_processar && alu_concluido) begin
            if (alu_cnt >= alu_rel) begin
                alu_concluido <= 1'b0;
                alu_cnt       <= 0;
            end else begin
                alu_cnt <= alu_cnt + 1;
            end
        end
    end

    // Architectural model: register file plus queue of accepted instructions
    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  rd;
    } exp_t;
    exp_t        q[$];
    exp_t        e;
    logic [15:0] m_regs [8];
    int          wb_count  = 0;
    logic        prev_proc = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (alu_processar && !prev_proc) begin
                chk("issue_queue_depth", q.size(), 1);
                if (q.size() > 0) begin
                    chk("alu_tp1", alu_tp1, q[0].a);
                    chk("alu_tp2", alu_tp2, q[0].b);
                    chk("alu_op", alu_op, q[0].op);
                end
            end
            if (alu_concluido) chk("ready_while_concluido", instr_ready, 0);
            if (alu_processar) chk("ready_while_processar", instr_ready, 0);
            if (wb_valid) begin
                wb_count++;
                chk("wb_queue_depth", q.size(), 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("wb_rd", wb_rd, e.rd);
                    chk("wb_data", wb_data, alu_f(e.op, e.a, e.b));
                    m_regs[e.rd] = alu_f(e.op, e.a, e.b);
                end
            end
        end
        prev_proc = alu_processar;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] a, input logic [15:0] d, input bit upd);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
        if (upd) m_regs[a] = d;
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input logic [15:0] exp);
        rd_addr = a;
        tick();
        chk(name, rd_data, exp);
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (!(instr_ready && q.size() == 0) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk("wait_ready_timeout", 0, 1);
    endtask

    task automatic wait_wb(input int budget);
        int n = 0;
        while (!wb_valid && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk("wait_wb_timeout", 0, 1);
    endtask

    // Returns in the cycle after the transfer edge (the LE cycle for legal ops)
    task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2);
        exp_t x;
        wait_ready(200);
        instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
        if (op <= 4'd9) begin
            x.op = op; x.a = m_regs[rs1]; x.b = m_regs[rs2]; x.rd = rd;
            q.push_back(x);
        end
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        q.delete();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int wb0;
        bit seen;
        reset = 1'b1; instr_valid = 1'b0; instr_op = 4'd0;
        instr_rd = 3'd0; instr_rs1 = 3'd0; instr_rs2 = 3'd0;
        ld_en = 1'b0; ld_addr = 3'd0; ld_data = 16'h0; rd_addr = 3'd0;
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset values
        chk("rst_instr_ready", instr_ready, 1);
        chk("rst_processar", alu_processar, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_err_op", err_op, 0);
        chk("rst_err_timeout", err_timeout, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_tp1", alu_tp1, 0);
        chk("rst_tp2", alu_tp2, 0);
        chk("rst_alu_op", alu_op, 0);
        for (int i = 0; i < 8; i++) rd_chk("rst_reg", 3'(i), 16'h0);

        // Basic add with latency checks
        load(3'd1, 16'h0007, 1);
        load(3'd2, 16'h0003, 1);
        wb0 = wb_count;
        issue(4'd0, 3'd3, 3'd1, 3'd2);
        chk("lat_le_processar", alu_processar, 0);
        tick();
        chk("lat_emite_processar", alu_processar, 1);
        cnt = 0;
        while (alu_processar && cnt < 100) begin
            cnt++;
            tick();
        end
        chk("processar_cycles", cnt, 4);
        chk("add_wb_valid", wb_valid, 1);
        chk("add_wb_rd", wb_rd, 3);
        chk("add_wb_data", wb_data, 16'h000A);
        wait_ready(100);
        chk("add_wb_count", wb_count - wb0, 1);
        rd_chk("add_r3", 3'd3, 16'h000A);

        // Back-to-back with slow concluido release; second uses new r3
        alu_rel = 3;
        issue(4'd1, 3'd3, 3'd1, 3'd2);
        issue(4'd2, 3'd4, 3'd3, 3'd2);
        wait_wb(100);
        load(3'd6, 16'h1234, 1);
        wait_ready(100);
        rd_chk("sub_r3", 3'd3, 16'h0004);
        rd_chk("mul_r4", 3'd4, 16'h000C);
        rd_chk("ld_other_r6", 3'd6, 16'h1234);
        alu_rel = 0;

        // Illegal opcode
        wb0 = wb_count;
        issue(4'hC, 3'd5, 3'd1, 3'd2);
        chk("illegal_err_op", err_op, 1);
        chk("illegal_ready", instr_ready, 1);
        tick();
        chk("illegal_err_op_pulse", err_op, 0);
        seen = 1'b0;
        repeat (6) begin
            if (alu_processar) seen = 1'b1;
            tick();
        end
        chk("illegal_no_processar", seen, 0);
        chk("illegal_no_wb", wb_count - wb0, 0);

        // ld_en to r1 during LE: operand must carry the old r1
        issue(4'd0, 3'd5, 3'd1, 3'd2);
        load(3'd1, 16'h0100, 1);
        wait_ready(100);
        rd_chk("le_old_r5", 3'd5, 16'h000A);
        rd_chk("le_new_r1", 3'd1, 16'h0100);

        // ld_en collides with writeback on r3: writeback wins
        load(3'd1, 16'h0007, 1);
        issue(4'd0, 3'd3, 3'd1, 3'd2);
        wait_wb(100);
        load(3'd3, 16'hFFFF, 0);
        wait_ready(100);
        rd_chk("collide_r3", 3'd3, 16'h000A);

        // rs1 = rs2 = rd
        issue(4'd0, 3'd2, 3'd2, 3'd2);
        wait_ready(100);
        rd_chk("self_r2", 3'd2, 16'h0006);

        // concluido in the last allowed EMITE cycle: completion wins
        alu_lat = 31;
        wb0 = wb_count;
        issue(4'd5, 3'd7, 3'd1, 3'd3);
        wait_ready(200);
        chk("edge_no_timeout", err_timeout, 0);
        chk("edge_wb_count", wb_count - wb0, 1);
        rd_chk("edge_r7", 3'd7, 16'h000D);
        alu_lat = 3;

        // ALU never answers
        alu_dead = 1'b1;
        issue(4'd0, 3'd7, 3'd1, 3'd2);
        tick();
        cnt = 0;
        while (alu_processar && cnt < 100) begin
            cnt++;
            tick();
        end
        chk("timeout_cycles", cnt, 32);
        chk("timeout_err", err_timeout, 1);
        chk("timeout_ready", instr_ready, 0);
        q.delete();
        repeat (5) tick();
        chk("timeout_sticky", err_timeout, 1);
        chk("timeout_ready_held", instr_ready, 0);
        chk("timeout_processar", alu_processar, 0);
        alu_dead = 1'b0;
        do_reset();
        chk("post_reset_err", err_timeout, 0);
        chk("post_reset_ready", instr_ready, 1);
        load(3'd1, 16'h0011, 1);
        load(3'd2, 16'h0022, 1);
        issue(4'd0, 3'd3, 3'd1, 3'd2);
        wait_ready(100);
        rd_chk("post_reset_add", 3'd3, 16'h0033);

        // Reset during EMITE
        alu_lat = 6;
        issue(4'd0, 3'd4, 3'd1, 3'd2);
        tick();
        chk("pre_reset_processar", alu_processar, 1);
        do_reset();
        chk("midop_processar", alu_processar, 0);
        chk("midop_ready", instr_ready, 1);
        for (int i = 0; i < 8; i++) rd_chk("midop_reg", 3'(i), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
